// File: rtl/nn_fp_pkg.sv
// Shared fp32 definitions for the neural-network output stages:
// field positions, constants, the argmax FSM state type and small
// classification helpers used by the comparators.
package nn_fp_pkg;

  localparam int FP32_W        = 32;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MANT_MSB = 22;
  localparam int FP32_MANT_LSB = 0;

  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } argmax_state_t;

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [FP32_W-1:0] x);
    return (&x[FP32_EXP_MSB:FP32_EXP_LSB]) && (|x[FP32_MANT_MSB:FP32_MANT_LSB]);
  endfunction

  // +0 or -0: every bit except the sign is clear.
  function automatic logic is_zero(input logic [FP32_W-1:0] x);
    return ~(|x[FP32_W-2:0]);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational fp32 "a strictly greater than b" in sign-magnitude order.
// Signed zeros compare equal, denormals order by raw bits, infinities order
// naturally, and a NaN operand never wins: NaN a is never greater, while any
// non-NaN a is greater than a NaN b.
module fp32_gt
  import nn_fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  // Priority-ordered compare: NaN handling, zero equality, sign, magnitude.
  always_comb begin
    gt = 1'b0;
    if (is_nan(a)) begin
      gt = 1'b0;
    end else if (is_nan(b)) begin
      gt = 1'b1;
    end else if (is_zero(a) && is_zero(b)) begin
      gt = 1'b0;
    end else if (a[31] != b[31]) begin
      gt = ~a[31];
    end else if (!a[31]) begin
      gt = (a[30:0] > b[30:0]);
    end else begin
      gt = (a[30:0] < b[30:0]);
    end
  end

endmodule

// File: rtl/neuron_argmax_stream.sv
// Streaming argmax over NUM_CLASSES fp32 scores, one beat per cycle.
// A running best value/index is kept with a single fp32_gt comparator; after
// the last beat the winner is held on a valid/ready output until taken.
// Optional build macro ARGMAX_NAN_FLAG_EN adds out_nan, a per-vector sticky
// flag reporting that some accepted beat was NaN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and out_* hold steady while
// out_valid is high and out_ready is low.
module neuron_argmax_stream
  import nn_fp_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [31:0]      out_value
`ifdef ARGMAX_NAN_FLAG_EN
  ,
  output logic             out_nan
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t    state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]      best_val_q, best_val_d;
  logic             beat_gt;
  logic             accept;
`ifdef ARGMAX_NAN_FLAG_EN
  logic             nan_q, nan_d;
`endif

  fp32_gt u_gt (
    .a  (in_data),
    .b  (best_val_q),
    .gt (beat_gt)
  );

  // Ready only while accumulating and out of reset.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_index = best_idx_q;
  assign out_value = best_val_q;
`ifdef ARGMAX_NAN_FLAG_EN
  assign out_nan   = nan_q;
`endif

  // State, beat counter and running best; everything clears asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= FP32_POS_ZERO;
`ifdef ARGMAX_NAN_FLAG_EN
      nan_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
`ifdef ARGMAX_NAN_FLAG_EN
      nan_q      <= nan_d;
`endif
    end
  end

  // Next-state: accumulate beats, hand off the result, clear wins over all.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
`ifdef ARGMAX_NAN_FLAG_EN
    nan_d      = nan_q;
`endif
    case (state_q)
      ACCUM: begin
        if (clear) begin
          cnt_d      = '0;
          best_idx_d = '0;
          best_val_d = FP32_POS_ZERO;
`ifdef ARGMAX_NAN_FLAG_EN
          nan_d      = 1'b0;
`endif
        end else if (accept) begin
          // Beat 0 always seeds the best; later beats must be strictly greater.
          if ((cnt_q == '0) || beat_gt) begin
            best_idx_d = cnt_q;
            best_val_d = in_data;
          end
`ifdef ARGMAX_NAN_FLAG_EN
          nan_d = nan_q | is_nan(in_data);
`endif
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (clear) begin
          state_d    = ACCUM;
          best_idx_d = '0;
          best_val_d = FP32_POS_ZERO;
`ifdef ARGMAX_NAN_FLAG_EN
          nan_d      = 1'b0;
`endif
        end else if (out_ready) begin
          state_d = ACCUM;
`ifdef ARGMAX_NAN_FLAG_EN
          nan_d   = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_neuron_argmax_stream.sv
// Bench for neuron_argmax_stream with NUM_CLASSES=4: directed vectors for the
// documented corner cases, then randomized vectors with random input gaps and
// random output backpressure, all checked against a real-valued argmax model.
module tb_neuron_argmax_stream;

  localparam int NC = 4;
  localparam int IW = 2;
  localparam int W  = 1 + IW + 32;  // {nan, index, value}

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [31:0]   out_value;
`ifdef ARGMAX_NAN_FLAG_EN
  logic          out_nan;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  bit hold    = 1'b0;
  bit rand_en = 1'b0;
  bit gap_en  = 1'b0;
  bit rnd     = 1'b1;

  logic [31:0] vec [NC];
  logic [W-1:0] e_bp;

  neuron_argmax_stream #(.NUM_CLASSES(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value)
`ifdef ARGMAX_NAN_FLAG_EN
    ,
    .out_nan   (out_nan)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rnd <= 1'($urandom_range(0, 1));
  assign out_ready = hold ? 1'b0 : (rand_en ? rnd : 1'b1);

  // ---------------- reference model ----------------
  function automatic bit tb_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Numeric value of an fp32 pattern; infinities map beyond the fp32 range.
  function automatic real fp_val(input logic [31:0] x);
    int  e;
    real r;
    e = int'(x[30:23]);
    if (e == 255)    r = 1.0e40;
    else if (e == 0) r = real'(x[22:0]) * (2.0 ** (-149));
    else             r = real'({1'b1, x[22:0]}) * (2.0 ** (e - 150));
    return x[31] ? -r : r;
  endfunction

  // First index holding the largest non-NaN score; index 0 if every score is NaN.
  function automatic logic [W-1:0] model(input logic [31:0] v[NC]);
    int  bi;
    real bv;
    bit  any_nan;
    bi = -1; bv = 0.0; any_nan = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (tb_is_nan(v[k])) any_nan = 1'b1;
      else if (bi < 0 || fp_val(v[k]) > bv) begin
        bi = k;
        bv = fp_val(v[k]);
      end
    end
    if (bi < 0) bi = 0;
    return {any_nan, IW'(bi), v[bi]};
  endfunction

  function automatic logic [31:0] rand_score();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 4) return $urandom;
    if (r <= 6) begin
      case ($urandom_range(0, 7))
        0: return 32'h0000_0000;
        1: return 32'h8000_0000;
        2: return 32'h7F80_0000;
        3: return 32'hFF80_0000;
        4: return 32'h7FC0_0000;
        5: return 32'h0000_0001;
        6: return 32'h8000_0001;
        default: return 32'h0000_0002;
      endcase
    end
    case ($urandom_range(0, 2))
      0: return 32'h3F80_0000;
      1: return 32'h4000_0000;
      default: return 32'hBF80_0000;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0d/%h required=none", out_index, out_value);
      end else begin
        e = exp_q.pop_front();
        check("out_index", 32'(out_index), 32'(e[W-2:32]));
        check("out_value", out_value, e[31:0]);
`ifdef ARGMAX_NAN_FLAG_EN
        check("out_nan", 32'(out_nan), 32'(e[W-1]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d);
    int n;
    n = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input logic [31:0] v[NC], input bit hold_result);
    exp_q.push_back(model(v));
    if (hold_result) hold = 1'b1;
    for (int k = 0; k < NC; k++) send_beat(v[k]);
    in_valid = 1'b0;
    check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_value", out_value,      32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Basic vector, then ready again the cycle after the handshake.
    vec = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'hBF80_0000};
    send_vec(vec, 1'b0);
    check("basic_index", 32'(out_index), 32'd1);
    check("basic_value", out_value, 32'h4040_0000);
    @(posedge clk); #1;
    check("basic_in_ready_after", 32'(in_ready), 32'd1);
    check("basic_out_valid_after", 32'(out_valid), 32'd0);

    // Ties, signed zeros, NaN, then a clean vector.
    vec = '{32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
    send_vec(vec, 1'b0); drain(20);
    vec = '{32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hBF80_0000};
    send_vec(vec, 1'b0); drain(20);
    vec = '{32'h7FC0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    send_vec(vec, 1'b0); drain(20);
    vec = '{32'hBF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000};
    send_vec(vec, 1'b0); drain(20);

    // Backpressure in DONE with in_valid held high.
    vec = '{32'h3F80_0000, 32'hC000_0000, 32'h7F80_0000, 32'h4000_0000};
    e_bp = model(vec);
    send_vec(vec, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h7F00_0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_index", 32'(out_index), 32'(e_bp[W-2:32]));
      check("bp_out_value", out_value,      e_bp[31:0]);
    end
    hold = 1'b0;
    vec = '{32'h4080_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    send_vec(vec, 1'b0); drain(20);

    // Clear in ACCUM after two beats, with a dropped beat in the clear cycle.
    send_beat(32'h4040_0000);
    send_beat(32'h4080_0000);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h7F00_0000;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    vec = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
    send_vec(vec, 1'b0); drain(20);

    // Clear in DONE discards the pending result.
    vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000};
    send_vec(vec, 1'b1);
    void'(exp_q.pop_back());
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_done_out_valid", 32'(out_valid), 32'd0);
    check("clear_done_in_ready",  32'(in_ready),  32'd1);
    hold = 1'b0;
    vec = '{32'hC040_0000, 32'hC000_0000, 32'hBF80_0000, 32'hC080_0000};
    send_vec(vec, 1'b0); drain(20);

    // Asynchronous reset while beat 2 is presented.
    send_beat(32'h3F80_0000);
    send_beat(32'h40A0_0000);
    check("pre_rst_best_value", out_value, 32'h40A0_0000);
    in_valid = 1'b1; in_data = 32'h4000_0000;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_index", 32'(out_index), 32'd0);
    check("async_rst_out_value", out_value,      32'h0);
    check("async_rst_in_ready",  32'(in_ready),  32'd0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    vec = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
    send_vec(vec, 1'b0); drain(20);

    // Randomized vectors with input gaps and output backpressure.
    rand_en = 1'b1;
    gap_en  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NC; k++) vec[k] = rand_score();
      send_vec(vec, 1'b0);
    end
    drain(200);
    rand_en = 1'b0;
    gap_en  = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
